bus_if_wb: RTL

Parametrised second-generation CPU bus interface between a pipeline memory stage and (a) the local scratchpad memory (SPM) and (b) the shared external bus via the arbiter's req/grant/strobe/ready handshake. It adds a posted-write buffer so external writes do not stall the pipeline, read-after-write ordering against that buffer, and a bus timeout with error reporting. It is instantiated once per fetch or memory stage.

---
 rtl/bus_if_wb_if.sv | 22 ++
 rtl/bus_if_wb.sv | 123 ++++++++++++
 2 files changed

// File: rtl/bus_if_wb_if.sv
// bus_if_wb_if: external arbiter bus with req/grant/strobe/ready handshake
interface bus_if_wb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;
  logic              bus_grnt_;
  logic              bus_req_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  modport master (
    input  bus_rd_data, bus_rdy_, bus_grnt_,
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );
  modport slave (
    output bus_rd_data, bus_rdy_, bus_grnt_,
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data
  );
endinterface

// File: rtl/bus_if_wb.sv
// bus_if_wb: CPU bus interface with SPM path, posted-write buffer and timed external bus master
module bus_if_wb #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int SPM_ADDR_W = 12,
  parameter int IDX_W      = 3,
  parameter int SPM_INDEX  = 1,
  parameter int WB_DEPTH   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  err,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  bus_if_wb_if.master           bus
);
  localparam int AW = $clog2(WB_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;
  state_t state, state_n;
  logic [ADDR_W+DATA_W-1:0] wb [WB_DEPTH];
  logic [AW:0] wp, rp;
  logic [15:0] cnt, cnt_n;
  logic [DATA_W-1:0] rd_buf, wd_n;
  logic [ADDR_W-1:0] addr_n;
  logic req_n, as_n, rw_n;
  logic valid, ext, empty, full, push, pop, tmo, done, rd_done;
  assign valid = !as_ && !flush;
  assign ext = addr[ADDR_W-1 -: IDX_W] != IDX_W'(SPM_INDEX);
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign tmo = state == ACCESS && bus.bus_rdy_ && cnt == 16'(TIMEOUT - 1);
  assign done = state == ACCESS && (!bus.bus_rdy_ || tmo);
  assign rd_done = done && bus.bus_rw;
  assign pop = done && !bus.bus_rw;
  assign push = valid && ext && !rw && !full && !stall;
  assign err = tmo;
  assign spm_as_ = !(valid && !ext && !stall);
  assign spm_addr = addr[SPM_ADDR_W-1:0];
  assign spm_rw = rw;
  assign spm_wr_data = wr_data;
  // a timed-out read returns zero because bus_rdy_ is still high
  assign rd_data = rd_done ? (bus.bus_rdy_ ? '0 : bus.bus_rd_data) :
                   (state == STALL && rw) ? rd_buf :
                   (!spm_as_ && rw) ? spm_rd_data : '0;
  assign busy = valid && ext && (rw ? !rd_done && state != STALL : full);
  always_comb begin
    state_n = state;
    req_n = bus.bus_req_;
    as_n = 1'b1;
    rw_n = bus.bus_rw;
    addr_n = bus.bus_addr;
    wd_n = bus.bus_wr_data;
    cnt_n = cnt;
    case (state)
      IDLE: if (!empty) begin
        {addr_n, wd_n} = wb[rp[AW-1:0]];
        rw_n = 1'b0;
        req_n = 1'b0;
        state_n = REQ;
      end else if (valid && ext && rw) begin
        addr_n = addr;
        rw_n = 1'b1;
        req_n = 1'b0;
        state_n = REQ;
      end
      REQ: if (!bus.bus_grnt_) begin
        as_n = 1'b0;
        cnt_n = '0;
        state_n = ACCESS;
      end
      ACCESS: begin
        cnt_n = cnt + 16'd1;
        if (done) begin
          req_n = 1'b1;
          rw_n = 1'b1;
          addr_n = '0;
          wd_n = '0;
          state_n = (bus.bus_rw && stall) ? STALL : IDLE;
        end
      end
      default: if (!stall) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) wb[wp[AW-1:0]] <= {addr, wr_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rd_buf <= '0;
      bus.bus_req_ <= 1'b1;
      bus.bus_as_ <= 1'b1;
      bus.bus_rw <= 1'b1;
      bus.bus_addr <= '0;
      bus.bus_wr_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (rd_done) rd_buf <= rd_data;
      bus.bus_req_ <= req_n;
      bus.bus_as_ <= as_n;
      bus.bus_rw <= rw_n;
      bus.bus_addr <= addr_n;
      bus.bus_wr_data <= wd_n;
    end
  end
endmodule
